// File: rtl/traffic_arbiter.sv
// Four-way intersection arbiter: round-robin green/yellow/all-red sequencing.
// Optional emergency preemption is compiled in with TRAFFIC_ARB_EMERG_EN.
module traffic_arbiter #(
    parameter int unsigned GREEN_MIN  = 8,
    parameter int unsigned GREEN_MAX  = 32,
    parameter int unsigned YELLOW_LEN = 4,
    parameter int unsigned ALLRED_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_a,
`ifdef TRAFFIC_ARB_EMERG_EN
    input  logic       emerg,
    input  logic [1:0] emerg_dir,
`endif
    input  logic [3:0] req,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALLRED
    } state_e;

    localparam logic [7:0] GMIN_LAST = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_LAST = 8'(GREEN_MAX - 1);
    localparam logic [7:0] Y_LAST    = 8'(YELLOW_LEN - 1);
    localparam logic [7:0] R_LAST    = 8'(ALLRED_LEN - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;

    logic       emg;
    logic [1:0] emg_dir;
    logic [1:0] idx;
    logic [1:0] rr_win;
    logic [1:0] win;
    logic       win_valid;
    logic [3:0] own_oh;
    logic       others;
    logic       emg_hold;
    logic       green_end;
    logic [2:0] lamps [4];

`ifdef TRAFFIC_ARB_EMERG_EN
    assign emg     = emerg;
    assign emg_dir = emerg_dir;
`else
    assign emg     = 1'b0;
    assign emg_dir = 2'd0;
`endif

    // Round-robin: nearest set bit above the last granted direction wins.
    always_comb begin
        idx    = '0;
        rr_win = ptr_q;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                rr_win = idx;
            end
        end
    end

    assign win       = emg ? emg_dir : rr_win;
    assign win_valid = emg | (|req);

    assign own_oh    = 4'b0001 << owner_q;
    assign others    = |(req & ~own_oh);
    assign emg_hold  = emg && (emg_dir == owner_q);
    assign green_end = emg
                    || (cnt_q == GMAX_LAST)
                    || ((cnt_q >= GMIN_LAST) && (others || !req[owner_q]));

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'(cnt_q != 8'hFF);
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_valid) begin
                    state_d = S_GREEN;
                    owner_d = win;
                    ptr_d   = win;
                end
            end
            S_GREEN: begin
                // Emergency owner keeps the counter parked until release.
                if (emg_hold) begin
                    cnt_d = '0;
                end else if (green_end) begin
                    state_d = S_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    state_d = S_ALLRED;
                    cnt_d   = '0;
                end
            end
            S_ALLRED: begin
                if (cnt_q == R_LAST) begin
                    cnt_d = '0;
                    if (win_valid) begin
                        state_d = S_GREEN;
                        owner_d = win;
                        ptr_d   = win;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        lamps = '{default: LAMP_RED};
        grant = '0;
        busy  = (state_q != S_IDLE);
        if (state_q == S_GREEN) begin
            lamps[owner_q] = LAMP_GRN;
            grant          = own_oh;
        end else if (state_q == S_YELLOW) begin
            lamps[owner_q] = LAMP_YEL;
            grant          = own_oh;
        end
    end

    assign n_lights = lamps[0];
    assign s_lights = lamps[1];
    assign e_lights = lamps[2];
    assign w_lights = lamps[3];

endmodule

// File: tb/tb_traffic_arbiter.sv
// Scenario bench for traffic_arbiter: expected per-cycle lamp/grant/busy
// values are queued from the phase timeline and popped after each edge.
module tb_traffic_arbiter;

    localparam int PI = 0;
    localparam int PG = 1;
    localparam int PY = 2;
    localparam int PR = 3;

    typedef struct packed {
        logic [11:0] lights;
        logic [3:0]  grant;
        logic        busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic [3:0] req = '0;
`ifdef TRAFFIC_ARB_EMERG_EN
    logic       emerg = 1'b0;
    logic [1:0] emerg_dir = 2'd0;
`endif
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic [3:0] grant;
    logic       busy;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t sb[$];

    traffic_arbiter #(
        .GREEN_MIN(8),
        .GREEN_MAX(32),
        .YELLOW_LEN(4),
        .ALLRED_LEN(2)
    ) dut (
        .clk(clk),
        .rst_a(rst_a),
`ifdef TRAFFIC_ARB_EMERG_EN
        .emerg(emerg),
        .emerg_dir(emerg_dir),
`endif
        .req(req),
        .n_lights(n_lights),
        .s_lights(s_lights),
        .e_lights(e_lights),
        .w_lights(w_lights),
        .grant(grant),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input int ph, input int dir);
        obs_t        o;
        logic [11:0] l;
        l = 12'h924;
        o.grant = '0;
        if (ph == PG) begin
            l[dir*3 +: 3] = 3'b001;
            o.grant[dir]  = 1'b1;
        end else if (ph == PY) begin
            l[dir*3 +: 3] = 3'b010;
            o.grant[dir]  = 1'b1;
        end
        o.lights = l;
        o.busy   = (ph != PI);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.lights = {w_lights, e_lights, s_lights, n_lights};
        o.grant  = grant;
        o.busy   = busy;
        return o;
    endfunction

    task automatic push(input int ph, input int dir, input int n);
        for (int k = 0; k < n; k++) sb.push_back(mk(ph, dir));
    endtask

    task automatic apply_reset();
        rst_a = 1'b1;
        req   = '0;
`ifdef TRAFFIC_ARB_EMERG_EN
        emerg = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PI, 0, 3);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b1;
            req   = (c == 0) ? 4'b0000 : 4'b1111;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_hold_n();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PG, 0, 32); push(PY, 0, 4); push(PR, 0, 2); push(PG, 0, 3);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b0;
            req   = 4'b0001;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL hold_n c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_alternate();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        for (int r = 0; r < 2; r++) begin
            push(PG, 0, 8); push(PY, 0, 4); push(PR, 0, 2);
            push(PG, 2, 8); push(PY, 2, 4); push(PR, 0, 2);
        end
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b0;
            req   = 4'b0101;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alternate c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_round_robin4();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        for (int d = 0; d < 4; d++) begin
            push(PG, d, 8); push(PY, d, 4); push(PR, 0, 2);
        end
        push(PG, 0, 2);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b0;
            req   = 4'b1111;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rr4 c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_late_req();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PG, 0, 8); push(PY, 0, 4); push(PR, 0, 2);
        push(PG, 1, 8); push(PY, 1, 2);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b0;
            req   = (c == 0) ? 4'b0001 : 4'b0011;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL late_req c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_drop_idle();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PG, 0, 10); push(PY, 0, 4); push(PR, 0, 2);
        push(PI, 0, 3); push(PG, 2, 3);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = 1'b0;
            req   = (c < 10) ? 4'b0001 : (c < 19) ? 4'b0000 : 4'b0100;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL drop_idle c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_yellow();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PG, 0, 8); push(PY, 0, 2); push(PI, 0, 1); push(PG, 3, 4);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a = (c == 10);
            req   = (c < 8) ? 4'b0001 : (c < 10) ? 4'b0000 : 4'b1000;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_yellow c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

`ifdef TRAFFIC_ARB_EMERG_EN
    task automatic test_emergency();
        obs_t got, exp;
        apply_reset();
        sb.delete();
        push(PG, 0, 1); push(PY, 0, 4); push(PR, 0, 2); push(PG, 2, 56);
        for (int c = 0; sb.size() > 0; c++) begin
            rst_a     = 1'b0;
            req       = 4'b0001;
            emerg     = (c >= 1) && (c <= 56);
            emerg_dir = 2'd2;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL emergency c=%0d got=%h exp=%h", c, got, exp);
            end
        end
        emerg = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hold_n();
        test_alternate();
        test_round_robin4();
        test_late_req();
        test_drop_idle();
        test_reset_yellow();
`ifdef TRAFFIC_ARB_EMERG_EN
        test_emergency();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_arbiter.md
TRAFFIC_ARBITER -- requirements
Module: traffic_arbiter

Interface
REQ-001 The block SHALL take parameter GREEN_MIN, default 8, minimum green cycles per grant (1..255).
REQ-002 The block SHALL take parameter GREEN_MAX, default 32, maximum green cycles per grant (GREEN_MIN..255).
REQ-003 The block SHALL take parameter YELLOW_LEN, default 4, exact yellow cycles (1..255).
REQ-004 The block SHALL take parameter ALLRED_LEN, default 2, exact all-red clearance cycles (1..255).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst_a  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port req  input  4  level vehicle-presence requests, bit0=N, bit1=S, bit2=E, bit3=W.
REQ-007 The block SHALL have ports n_lights, s_lights, e_lights, w_lights  output  3 each  lamp code: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-008 The block SHALL have port grant  output  4  one-hot owner of the intersection (same bit order as req), 0 when none.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, GREEN, YELLOW, ALLRED; one 8-bit cycle counter, cleared on every state entry.
REQ-011 In IDLE all lamps SHALL be red and grant SHALL be 0; any req bit set -> GREEN next cycle for the arbitration winner.
REQ-012 Arbitration SHALL be round-robin: winner = first set req bit searching upward (wrapping 3->0) from the bit after the last granted direction.
REQ-013 Requests SHALL be sampled level-sensitively, never latched; a request deasserted before arbitration is lost.
REQ-014 In GREEN, the granted direction's lamp SHALL be 3'b001, all others 3'b100, and grant SHALL hold the winner.
REQ-015 GREEN SHALL last at least GREEN_MIN cycles; after that it SHALL go to YELLOW at the first cycle where another req bit is set or the own req bit is clear.
REQ-016 GREEN SHALL go to YELLOW after exactly GREEN_MAX cycles regardless of requests.
REQ-017 YELLOW SHALL last exactly YELLOW_LEN cycles with the granted lamp 3'b010; grant stays asserted.
REQ-018 ALLRED SHALL last exactly ALLRED_LEN cycles, all lamps red, grant 0.
REQ-019 On the last ALLRED cycle, any req set -> GREEN for the new winner (the same direction may win again if it is the only requester); otherwise -> IDLE.
REQ-020 At no cycle SHALL more than one lamp be non-red.
REQ-021 Lamp outputs and grant SHALL decode from registered state only, changing in the same cycle as the state register.

Reset
REQ-022 While rst_a is high at a clk edge: state IDLE, counter 0, all lamps 3'b100, grant 0, busy 0, last-granted pointer = W (N wins first).
REQ-023 Reset asserted mid-GREEN or mid-YELLOW SHALL force all-red on the next edge with no yellow or clearance phase.

Configuration
REQ-024 With macro TRAFFIC_ARB_EMERG_EN defined, inputs emerg (1) and emerg_dir (2, 0=N..3=W) SHALL exist.
REQ-025 With TRAFFIC_ARB_EMERG_EN, emerg high in GREEN SHALL force YELLOW next cycle, ignoring GREEN_MIN, unless the granted direction equals emerg_dir, in which case GREEN is held.
REQ-026 With TRAFFIC_ARB_EMERG_EN, arbitration in IDLE or at ALLRED end SHALL select emerg_dir while emerg is high, and that GREEN SHALL be held while emerg is high, ignoring GREEN_MAX.
REQ-027 After emergency release, the green SHALL proceed as a normal green with its counter restarted at 0, and the round-robin pointer SHALL be set to emerg_dir.
REQ-028 Without TRAFFIC_ARB_EMERG_EN, the emerg and emerg_dir ports SHALL be absent and behaviour SHALL be exactly REQ-010..REQ-021.

Verification (defaults 8/32/4/2)
REQ-029 Reset, then req=4'b0001 held: N green 1 cycle after IDLE, held 32 cycles, 4 yellow, 2 all-red, then N green again.
REQ-030 req=4'b0101 constant: grants alternate N,E,N,E; each green is exactly 8 cycles and separated by 4 yellow + 2 all-red cycles.
REQ-031 N green, S req rises at green cycle 2: yellow starts after green cycle 8, then S green after 2 all-red cycles.
REQ-032 N green, req drops to 0 at cycle 10: yellow the next cycle, all-red, IDLE, busy=0, all lamps 3'b100.
REQ-033 rst_a pulsed during YELLOW: the next cycle shows all lamps 3'b100 and grant 0; with req=4'b1000, the first grant goes to W.
REQ-034 EMERG_EN, N green cycle 1, emerg=1, emerg_dir=2: yellow next cycle, then all-red, then E green held while emerg=1 for 50 cycles.
